// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues {op,len} commands in a small FIFO and replays
// each one as a registered J/K drive for len+1 cycles.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   cmd_valid/ready - upstream handshake, push when both high
//   cmd_op[1:0]     - 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len[3:0]    - command is applied for cmd_len+1 cycles
//   J, K            - registered drive to the downstream JK flip-flop
//   busy            - high while a command is being applied
//   q_in            - Q fed back from the downstream flip-flop
//   mismatch        - sticky checker flag
//
// Build option: define JKSEQ_CHECK_EN to enable the Q-prediction checker;
// without it mismatch is tied low and q_in is ignored.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_len,
    output logic       J,
    output logic       K,
    output logic       busy,
    input  logic       q_in,
    output logic       mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [5:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    // executor
    state_t        state_q, state_d;
    logic [3:0]    rem_q, rem_d;
    logic          j_q, j_d;
    logic          k_q, k_d;

    logic          push;
    logic          pop;
    logic          empty;
    logic [5:0]    head;

    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

    // A full FIFO refuses a push even when a pop frees a slot on the
    // same edge; the upstream simply retries next cycle.
    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {cmd_op, cmd_len};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // FSM state register (J/K are registered outputs of the FSM)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // FSM next state: a finishing command chains straight into the next
    // queued one so there is no idle bubble between commands.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    rem_d   = head[3:0];
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end else if (!empty) begin
                    pop   = 1'b1;
                    rem_d = head[3:0];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the op encoding is already {J,K}
    always_comb begin
        j_d  = j_q;
        k_d  = k_q;
        busy = (state_q == APPLY);
        if (pop) begin
            j_d = head[5];
            k_d = head[4];
        end else if (state_d == IDLE) begin
            j_d = 1'b0;
            k_d = 1'b0;
        end
    end

    assign J = j_q;
    assign K = k_q;

`ifdef JKSEQ_CHECK_EN
    logic pred_q;
    logic mism_q;

    // Predicted Q follows the J/K that were on the wire before the edge,
    // exactly as the downstream flip-flop sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_q <= 1'b0;
            mism_q <= 1'b0;
        end else begin
            unique case ({j_q, k_q})
                2'b00: pred_q <= pred_q;
                2'b01: pred_q <= 1'b0;
                2'b10: pred_q <= 1'b1;
                2'b11: pred_q <= ~pred_q;
                default: pred_q <= pred_q;
            endcase
            if (q_in != pred_q) begin
                mism_q <= 1'b1;
            end
        end
    end

    assign mismatch = mism_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign mismatch    = 1'b0;
`endif

endmodule
